// File: rtl/uart_tx_sched_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_sched_if
//
// Purpose : groups the client-request bus, the frame-builder/PISO handshake
//           and the status/watchdog signals of uart_tx_sched.
//
// Modports:
//   master - the scheduler. It owns req_ready, data_input, line_control_reg,
//            piso_start, grant_id, busy and timeout_err.
//   slave  - the environment: the requesters, the frame builder/PISO and
//            whoever clears the watchdog flag.
//
// Signals:
//   req_valid        [NUM_REQ]    per-requester request, held until accepted
//   req_data         [8*NUM_REQ]  requester i payload in [8i+7:8i]
//   req_lcr          [5*NUM_REQ]  requester i line control in [5i+4:5i]
//   req_ready        [NUM_REQ]    one-hot accept pulse
//   data_input       [8]          latched payload to the frame builder
//   line_control_reg [5]          latched line-control word
//   piso_start       [1]          high while a frame is being transmitted
//   piso_done        [1]          PISO finished shifting the frame
//   grant_id         [clog2(N)]   current / last granted requester
//   busy             [1]          scheduler not idle
//   err_clr          [1]          clears timeout_err
//   timeout_err      [1]          sticky watchdog flag
// -----------------------------------------------------------------------------
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4
) ();
  localparam int GID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [5*NUM_REQ-1:0] req_lcr;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           data_input;
  logic [4:0]           line_control_reg;
  logic                 piso_start;
  logic                 piso_done;
  logic [GID_W-1:0]     grant_id;
  logic                 busy;
  logic                 err_clr;
  logic                 timeout_err;

  modport master (
    input  req_valid, req_data, req_lcr, piso_done, err_clr,
    output req_ready, data_input, line_control_reg, piso_start, grant_id,
           busy, timeout_err
  );

  modport slave (
    output req_valid, req_data, req_lcr, piso_done, err_clr,
    input  req_ready, data_input, line_control_reg, piso_start, grant_id,
           busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_sched.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_sched
//
// Purpose : round-robin scheduler sharing one UART transmit path (frame
//           builder + PISO shifter) among NUM_REQ requesters. One byte and
//           line-control word is accepted per grant, presented to the frame
//           builder, and piso_start is held until piso_done. An idle gap of
//           GAP_CYCLES cycles separates frames before re-arbitration.
//
// Optional feature macro: UART_TX_WATCHDOG_EN
//   defined   - a WAIT-state cycle counter aborts a frame after TIMEOUT cycles
//               without piso_done and sets the sticky timeout_err flag
//               (err_clr clears it; a simultaneous new timeout wins).
//   undefined - WAIT waits forever; timeout_err is tied low, err_clr ignored.
//
// Parameters:
//   NUM_REQ    number of requesters (2..8); must match the interface instance
//   GAP_CYCLES idle cycles between frames (0..255)
//   TIMEOUT    WAIT cycles before a watchdog abort (watchdog build only)
//
// Ports:
//   baud_clk  single clock, all state changes on its rising edge
//   rst       asynchronous active-high reset; abandons any frame in flight
//   bus       uart_tx_sched_if.master (requests, PISO handshake, status)
// -----------------------------------------------------------------------------
module uart_tx_sched #(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 64
) (
  input  logic            baud_clk,
  input  logic            rst,
  uart_tx_sched_if.master bus
);

  localparam int GID_W = $clog2(NUM_REQ);

  typedef logic [GID_W-1:0] gid_t;
  typedef logic [GID_W:0]   gid_ext_t;

  localparam gid_ext_t   N_EXT    = gid_ext_t'(NUM_REQ);
  localparam gid_t       GID_LAST = gid_t'(NUM_REQ - 1);
  // Last gap count; only meaningful when GAP_CYCLES > 0 (GAP is never
  // entered otherwise).
  localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0] state_q, state_d;
  gid_t       rr_ptr_q, rr_ptr_d;
  gid_t       grant_id_q, grant_id_d;
  logic [7:0] data_q, data_d;
  logic [4:0] lcr_q, lcr_d;
  logic       piso_start_q, piso_start_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;

`ifdef UART_TX_WATCHDOG_EN
  localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_err_q, timeout_err_d;
`endif

  // ---------------------------------------------------------------------------
  // Per-requester payload slices and the one-hot accept vector
  // ---------------------------------------------------------------------------
  logic [7:0]         data_slice [NUM_REQ];
  logic [4:0]         lcr_slice  [NUM_REQ];
  logic [NUM_REQ-1:0] ready_vec;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign data_slice[gi] = bus.req_data[8*gi +: 8];
    assign lcr_slice[gi]  = bus.req_lcr[5*gi +: 5];
    assign ready_vec[gi]  = (state_q == LOAD) && (grant_id_q == gid_t'(gi));
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter
  //
  // The request vector is rotated so that bit 0 is requester rr_ptr; the
  // lowest set bit of the rotated vector is the offset of the winner from
  // rr_ptr, which gives "first set bit searching upward with wrap".
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] rot_valid;
  logic [NUM_REQ-1:0] first_hot;
  logic [NUM_REQ-1:0] enc_terms [GID_W];
  gid_t               pri_offset;
  gid_ext_t           win_sum;
  gid_t               winner;
  logic               any_req;

  assign rot_valid = NUM_REQ'({bus.req_valid, bus.req_valid} >> rr_ptr_q);
  assign any_req   = |bus.req_valid;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pri
    if (gi == 0) begin : g_first
      assign first_hot[gi] = rot_valid[0];
    end else begin : g_rest
      assign first_hot[gi] = rot_valid[gi] & ~(|rot_valid[gi-1:0]);
    end
  end

  // One-hot to binary: offset bit b is the OR of every hot position whose
  // index has bit b set.
  for (genvar bi = 0; bi < GID_W; bi++) begin : g_enc_bit
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_enc_term
      if (((gi >> bi) & 1) == 1) begin : g_on
        assign enc_terms[bi][gi] = first_hot[gi];
      end else begin : g_off
        assign enc_terms[bi][gi] = 1'b0;
      end
    end
    assign pri_offset[bi] = |enc_terms[bi];
  end

  assign win_sum = {1'b0, rr_ptr_q} + {1'b0, pri_offset};
  assign winner  = (win_sum >= N_EXT) ? gid_t'(win_sum - N_EXT) : gid_t'(win_sum);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic leave_wait;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    data_d       = data_q;
    lcr_d        = lcr_q;
    piso_start_d = piso_start_q;
    gap_cnt_d    = gap_cnt_q;
    leave_wait   = 1'b0;
`ifdef UART_TX_WATCHDOG_EN
    wd_cnt_d      = wd_cnt_q;
    // Clear first so that a timeout raised below in the same cycle wins.
    timeout_err_d = bus.err_clr ? 1'b0 : timeout_err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_id_d = winner;
          state_d    = LOAD;
        end
      end

      LOAD: begin
        if (bus.req_valid[grant_id_q]) begin
          data_d       = data_slice[grant_id_q];
          lcr_d        = lcr_slice[grant_id_q];
          rr_ptr_d     = (grant_id_q == GID_LAST) ? '0 : grant_id_q + 1'b1;
          // Raised together with the data latch so the frame builder sees
          // valid data on the first piso_start cycle.
          piso_start_d = 1'b1;
          state_d      = START;
        end else begin
          // Requester withdrew before the accept: drop the grant silently.
          state_d = IDLE;
        end
      end

      START: begin
        // piso_done is deliberately not looked at here.
`ifdef UART_TX_WATCHDOG_EN
        wd_cnt_d = '0;
`endif
        state_d = WAIT;
      end

      WAIT: begin
        leave_wait = bus.piso_done;
`ifdef UART_TX_WATCHDOG_EN
        if (!bus.piso_done) begin
          if (wd_cnt_q == WD_LAST) begin
            leave_wait    = 1'b1;
            timeout_err_d = 1'b1;
          end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
          end
        end
`endif
        if (leave_wait) begin
          piso_start_d = 1'b0;
          gap_cnt_d    = '0;
          state_d      = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end

      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end

      default: begin
        piso_start_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      data_q       <= '0;
      lcr_q        <= '0;
      piso_start_q <= 1'b0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      data_q       <= data_d;
      lcr_q        <= lcr_d;
      piso_start_q <= piso_start_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

`ifdef UART_TX_WATCHDOG_EN
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  // Without the watchdog the flag is constant and err_clr has no effect.
  logic unused_err_clr;
  assign unused_err_clr  = bus.err_clr;
  assign bus.timeout_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.req_ready        = ready_vec;
  assign bus.data_input       = data_q;
  assign bus.line_control_reg = lcr_q;
  assign bus.piso_start       = piso_start_q;
  assign bus.grant_id         = grant_id_q;
  assign bus.busy             = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
`timescale 1ns/1ps
// Self-checking bench for uart_tx_sched.
// dut_a: GAP_CYCLES=1, TIMEOUT=64. dut_b: GAP_CYCLES=0, TIMEOUT=8.
// Inputs are driven 1 ns after the rising edge; outputs are read in the same
// window (all outputs are registered or decoded from state only).
module tb_uart_tx_sched;
  localparam int NREQ  = 4;
  localparam int GAP_A = 1;

  logic baud_clk = 1'b0;
  logic rst      = 1'b1;
  always #5 baud_clk = ~baud_clk;

  uart_tx_sched_if #(.NUM_REQ(NREQ)) a_if ();
  uart_tx_sched_if #(.NUM_REQ(NREQ)) b_if ();

  uart_tx_sched #(.NUM_REQ(NREQ), .GAP_CYCLES(GAP_A), .TIMEOUT(64)) dut_a (
    .baud_clk(baud_clk), .rst(rst), .bus(a_if)
  );
  uart_tx_sched #(.NUM_REQ(NREQ), .GAP_CYCLES(0), .TIMEOUT(8)) dut_b (
    .baud_clk(baud_clk), .rst(rst), .bus(b_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: round-robin pointer and the requesters' payloads.
  int         rr_a = 0;
  int         rr_b = 0;
  logic [7:0] a_data [NREQ];
  logic [4:0] a_lcr  [NREQ];

  task automatic tick();
    @(posedge baud_clk);
    #1;
  endtask

  // Spec rule: first valid requester at or after ptr, wrapping.
  function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic a_drive();
    for (int i = 0; i < NREQ; i++) begin
      a_if.req_data[8*i +: 8] = a_data[i];
      a_if.req_lcr[5*i +: 5]  = a_lcr[i];
    end
  endtask

  task automatic a_rand_payloads();
    for (int i = 0; i < NREQ; i++) begin
      a_data[i] = 8'($urandom);
      a_lcr[i]  = 5'($urandom);
    end
    a_drive();
  endtask

  // One complete frame on dut_a. Entered in an IDLE window with req_valid
  // already set; returns in the IDLE window after the gap.
  task automatic a_frame(input int wait_len, input bit persist);
    int               w;
    logic [NREQ-1:0]  exp_ready;
    logic [1:0]       exp_gid;
    logic [7:0]       exp_d;
    logic [4:0]       exp_l;
    w         = rr_pick(a_if.req_valid, rr_a);
    exp_ready = NREQ'(1) << w;
    exp_gid   = 2'(w);
    exp_d     = a_data[w];
    exp_l     = a_lcr[w];

    tick();  // LOAD
    checks++;
    if ({a_if.req_ready, a_if.grant_id, a_if.busy, a_if.piso_start} !==
        {exp_ready, exp_gid, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL a_load: got ready=%b gid=%0d busy=%b start=%b, want ready=%b gid=%0d busy=1 start=0",
               a_if.req_ready, a_if.grant_id, a_if.busy, a_if.piso_start, exp_ready, exp_gid);
    end

    tick();  // START
    checks++;
    if ({a_if.data_input, a_if.line_control_reg, a_if.piso_start, a_if.req_ready} !==
        {exp_d, exp_l, 1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL a_start: got data=%h lcr=%b start=%b ready=%b, want data=%h lcr=%b start=1 ready=0000",
               a_if.data_input, a_if.line_control_reg, a_if.piso_start, a_if.req_ready, exp_d, exp_l);
    end
    rr_a = (w + 1) % NREQ;
    if (persist) begin
      a_data[w] = 8'($urandom);
      a_lcr[w]  = 5'($urandom);
      a_drive();
    end else begin
      a_if.req_valid[w] = 1'b0;
    end

    tick();  // first WAIT cycle
    for (int j = 1; j <= wait_len; j++) begin
      checks++;
      if ({a_if.piso_start, a_if.busy, a_if.req_ready, a_if.timeout_err} !== {1'b1, 1'b1, 4'b0000, 1'b0}) begin
        errors++;
        $display("FAIL a_wait%0d: got start=%b busy=%b ready=%b terr=%b, want start=1 busy=1 ready=0000 terr=0",
                 j, a_if.piso_start, a_if.busy, a_if.req_ready, a_if.timeout_err);
      end
      a_if.piso_done = (j == wait_len);
      tick();
    end
    a_if.piso_done = 1'b0;

    for (int g = 1; g <= GAP_A; g++) begin
      checks++;
      if ({a_if.busy, a_if.piso_start, a_if.req_ready} !== {1'b1, 1'b0, 4'b0000}) begin
        errors++;
        $display("FAIL a_gap%0d: got busy=%b start=%b ready=%b, want busy=1 start=0 ready=0000",
                 g, a_if.busy, a_if.piso_start, a_if.req_ready);
      end
      tick();
    end

    checks++;
    if ({a_if.busy, a_if.piso_start, a_if.req_ready, a_if.data_input, a_if.line_control_reg} !==
        {1'b0, 1'b0, 4'b0000, exp_d, exp_l}) begin
      errors++;
      $display("FAIL a_idle: got busy=%b start=%b ready=%b data=%h lcr=%b, want busy=0 start=0 ready=0000 data=%h lcr=%b",
               a_if.busy, a_if.piso_start, a_if.req_ready, a_if.data_input, a_if.line_control_reg, exp_d, exp_l);
    end
    $display("frame a: grant %0d data %h lcr %b wait %0d", w, exp_d, exp_l, wait_len);
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({a_if.req_ready, a_if.data_input, a_if.line_control_reg, a_if.piso_start,
         a_if.grant_id, a_if.busy, a_if.timeout_err} !== 22'd0) begin
      errors++;
      $display("FAIL reset_a: got ready=%b data=%h lcr=%b start=%b gid=%0d busy=%b terr=%b, want all 0",
               a_if.req_ready, a_if.data_input, a_if.line_control_reg, a_if.piso_start,
               a_if.grant_id, a_if.busy, a_if.timeout_err);
    end
    checks++;
    if ({b_if.req_ready, b_if.piso_start, b_if.grant_id, b_if.busy, b_if.timeout_err} !== 9'd0) begin
      errors++;
      $display("FAIL reset_b: got ready=%b start=%b gid=%0d busy=%b terr=%b, want all 0",
               b_if.req_ready, b_if.piso_start, b_if.grant_id, b_if.busy, b_if.timeout_err);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({a_if.busy, a_if.req_ready} !== 5'd0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b ready=%b, want busy=0 ready=0000", a_if.busy, a_if.req_ready);
    end
    $display("reset done");
  endtask

  task automatic test_round_robin();
    a_rand_payloads();
    a_if.req_valid = 4'b1111;
    for (int f = 0; f < 5; f++) a_frame(2 + f, 1'b1);
    a_if.req_valid = '0;
  endtask

  task automatic test_single();
    a_rand_payloads();
    a_data[1] = 8'hA5;
    a_lcr[1]  = 5'b00111;
    a_drive();
    a_if.req_valid = 4'b0010;
    a_frame(10, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    a_rand_payloads();
    a_if.req_valid = 4'b1000;
    tick();  // LOAD
    tick();  // START
    a_if.req_valid = '0;
    tick();  // WAIT
    tick();
    checks++;
    if (a_if.piso_start !== 1'b1) begin
      errors++;
      $display("FAIL midwait_pre: got start=%b, want 1", a_if.piso_start);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({a_if.piso_start, a_if.busy, a_if.req_ready, a_if.data_input} !== 15'd0) begin
      errors++;
      $display("FAIL midwait_async: got start=%b busy=%b ready=%b data=%h, want all 0",
               a_if.piso_start, a_if.busy, a_if.req_ready, a_if.data_input);
    end
    tick();
    rst  = 1'b0;
    rr_a = 0;
    rr_b = 0;
    a_if.req_valid = 4'b1111;
    a_frame(3, 1'b0);
    a_if.req_valid = '0;
  endtask

  task automatic test_valid_drop();
    logic [7:0] prev_d;
    logic [4:0] prev_l;
    prev_d = a_if.data_input;
    prev_l = a_if.line_control_reg;
    a_rand_payloads();
    a_if.req_valid = 4'b0100;
    tick();  // LOAD
    checks++;
    if (a_if.req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL drop_load: got ready=%b, want 0100", a_if.req_ready);
    end
    a_if.req_valid = '0;
    tick();
    checks++;
    if ({a_if.busy, a_if.piso_start, a_if.data_input, a_if.line_control_reg} !== {1'b0, 1'b0, prev_d, prev_l}) begin
      errors++;
      $display("FAIL drop_idle: got busy=%b start=%b data=%h lcr=%b, want busy=0 start=0 data=%h lcr=%b",
               a_if.busy, a_if.piso_start, a_if.data_input, a_if.line_control_reg, prev_d, prev_l);
    end
    $display("drop: requester 2 withdrew, rr pointer stays %0d", rr_a);
    a_if.req_valid = 4'b1111;
    a_frame(2, 1'b0);
    a_if.req_valid = '0;
  endtask

  task automatic test_gap_zero();
    b_if.req_data  = 32'h44_33_22_11;
    b_if.req_lcr   = 20'h0_1234;
    b_if.req_valid = 4'b0011;
    tick();  // LOAD
    checks++;
    if (b_if.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL gap0_load: got ready=%b, want 0001", b_if.req_ready);
    end
    tick();  // START
    b_if.req_valid = 4'b0010;
    b_if.piso_done = 1'b1;   // must be ignored in START
    checks++;
    if ({b_if.piso_start, b_if.data_input} !== {1'b1, 8'h11}) begin
      errors++;
      $display("FAIL gap0_start: got start=%b data=%h, want start=1 data=11", b_if.piso_start, b_if.data_input);
    end
    tick();  // WAIT 1
    b_if.piso_done = 1'b0;
    checks++;
    if ({b_if.piso_start, b_if.busy} !== 2'b11) begin
      errors++;
      $display("FAIL gap0_ignore: got start=%b busy=%b, want start=1 busy=1", b_if.piso_start, b_if.busy);
    end
    tick();  // WAIT 2
    tick();  // WAIT 3
    b_if.piso_done = 1'b1;
    tick();
    b_if.piso_done = 1'b0;
    checks++;
    if ({b_if.piso_start, b_if.busy, b_if.timeout_err} !== 3'b000) begin
      errors++;
      $display("FAIL gap0_end: got start=%b busy=%b terr=%b, want 000", b_if.piso_start, b_if.busy, b_if.timeout_err);
    end
    tick();
    checks++;
    if ({b_if.req_ready, b_if.grant_id} !== {4'b0010, 2'd1}) begin
      errors++;
      $display("FAIL gap0_next: got ready=%b gid=%0d, want ready=0010 gid=1", b_if.req_ready, b_if.grant_id);
    end
    tick();  // START
    b_if.req_valid = '0;
    tick();  // WAIT
    b_if.piso_done = 1'b1;
    tick();
    b_if.piso_done = 1'b0;
    rr_b = 2;
    checks++;
    if ({b_if.busy, b_if.data_input, b_if.line_control_reg} !== {1'b0, 8'h22, 5'(20'h0_1234 >> 5)}) begin
      errors++;
      $display("FAIL gap0_last: got busy=%b data=%h lcr=%b, want busy=0 data=22 lcr=%b",
               b_if.busy, b_if.data_input, b_if.line_control_reg, 5'(20'h0_1234 >> 5));
    end
    $display("frame b: two frames with zero gap");
  endtask

  task automatic test_random();
    for (int f = 0; f < 20; f++) begin
      a_rand_payloads();
      a_if.req_valid = 4'($urandom_range(1, 15));
      a_frame($urandom_range(1, 6), 1'($urandom));
    end
    a_if.req_valid = '0;
  endtask

`ifdef UART_TX_WATCHDOG_EN
  task automatic test_watchdog();
    int w;
    b_if.req_valid = 4'b0100;
    tick();  // LOAD
    tick();  // START
    b_if.req_valid = '0;
    tick();  // WAIT 1
    for (int j = 1; j <= 8; j++) begin
      checks++;
      if ({b_if.piso_start, b_if.timeout_err} !== 2'b10) begin
        errors++;
        $display("FAIL wd_wait%0d: got start=%b terr=%b, want start=1 terr=0", j, b_if.piso_start, b_if.timeout_err);
      end
      tick();
    end
    checks++;
    if ({b_if.piso_start, b_if.timeout_err, b_if.busy} !== 3'b010) begin
      errors++;
      $display("FAIL wd_fire: got start=%b terr=%b busy=%b, want start=0 terr=1 busy=0",
               b_if.piso_start, b_if.timeout_err, b_if.busy);
    end
    rr_b = 3;
    b_if.err_clr = 1'b1;
    tick();
    b_if.err_clr = 1'b0;
    checks++;
    if (b_if.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL wd_clear: got terr=%b, want 0", b_if.timeout_err);
    end
    b_if.req_valid = 4'b0001;
    w = rr_pick(b_if.req_valid, rr_b);
    tick();  // LOAD
    checks++;
    if (b_if.req_ready !== (NREQ'(1) << w)) begin
      errors++;
      $display("FAIL wd_next: got ready=%b, want %b", b_if.req_ready, NREQ'(1) << w);
    end
    tick();  // START
    b_if.req_valid = '0;
    tick();  // WAIT
    b_if.piso_done = 1'b1;
    tick();
    b_if.piso_done = 1'b0;
    checks++;
    if ({b_if.busy, b_if.timeout_err, b_if.data_input} !== {1'b0, 1'b0, 8'h11}) begin
      errors++;
      $display("FAIL wd_served: got busy=%b terr=%b data=%h, want busy=0 terr=0 data=11",
               b_if.busy, b_if.timeout_err, b_if.data_input);
    end
    $display("watchdog: timeout raised, cleared, next frame served");
  endtask
`endif

  initial begin
    a_if.req_valid = '0;
    a_if.req_data  = '0;
    a_if.req_lcr   = '0;
    a_if.piso_done = 1'b0;
    a_if.err_clr   = 1'b0;
    b_if.req_valid = '0;
    b_if.req_data  = '0;
    b_if.req_lcr   = '0;
    b_if.piso_done = 1'b0;
    b_if.err_clr   = 1'b0;

    test_reset();
    test_round_robin();
    test_single();
    test_reset_mid_wait();
    test_valid_drop();
    test_gap_zero();
    test_random();
`ifdef UART_TX_WATCHDOG_EN
    test_watchdog();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
